// File: rtl/apb_fsm_controller_if.sv
// AHB-slave-side inputs and APB master outputs of the bridge controller.
// slave modport is the controller's view; master modport is the driver's view.
interface apb_fsm_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 3
);
  logic              valid;
  logic              Hwrite;
  logic              Hwritereg;
  logic [ADDR_W-1:0] Haddr;
  logic [ADDR_W-1:0] Haddr1;
  logic [ADDR_W-1:0] Haddr2;
  logic [DATA_W-1:0] Hwdata;
  logic [DATA_W-1:0] Hwdata1;
  logic [NSEL-1:0]   tempselx;

  logic [NSEL-1:0]   Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Hreadyout;

  modport slave (
    input  valid, Hwrite, Hwritereg, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1, tempselx,
    output Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout
  );

  modport master (
    output valid, Hwrite, Hwritereg, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1, tempselx,
    input  Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout
  );
endinterface

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge control FSM: setup/enable APB phases, all outputs registered.
// Read setup one cycle after valid, writes wait one cycle for data; Hreadyout low during each setup.
module apb_fsm_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 3
) (
  input  logic                 Hclk,
  input  logic                 Hresetin,
  apb_fsm_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_READ,
    ST_WRITE,
    ST_WRITEP,
    ST_RENABLE,
    ST_WENABLE,
    ST_WENABLEP
  } state_t;

  state_t            r_state;
  logic [NSEL-1:0]   r_pselx;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_hreadyout;

  logic w_rd_req;
  logic w_wr_req;

  assign w_rd_req = bus.valid & ~bus.Hwrite;
  assign w_wr_req = bus.valid &  bus.Hwrite;

  always_ff @(posedge Hclk) begin
    if (Hresetin) begin
      r_state     <= ST_IDLE;
      r_pselx     <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_hreadyout <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_RENABLE, ST_WENABLE: begin
          if (w_rd_req) begin
            r_state     <= ST_READ;
            r_paddr     <= bus.Haddr;
            r_pwrite    <= 1'b0;
            r_pselx     <= bus.tempselx;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b0;
          end else if (w_wr_req) begin
            r_state     <= ST_WWAIT;
            r_pselx     <= '0;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b1;
          end else begin
            r_state     <= ST_IDLE;
            r_pselx     <= '0;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b1;
          end
        end

        // Write data arrives this cycle; the address is one cycle old.
        ST_WWAIT: begin
          r_state     <= bus.valid ? ST_WRITEP : ST_WRITE;
          r_paddr     <= bus.Haddr1;
          r_pwdata    <= bus.Hwdata;
          r_pwrite    <= 1'b1;
          r_pselx     <= bus.tempselx;
          r_penable   <= 1'b0;
          r_hreadyout <= 1'b0;
        end

        ST_READ: begin
          r_state     <= ST_RENABLE;
          r_penable   <= 1'b1;
          r_hreadyout <= 1'b1;
        end

        ST_WRITE: begin
          r_state     <= bus.valid ? ST_WENABLEP : ST_WENABLE;
          r_penable   <= 1'b1;
          r_hreadyout <= 1'b1;
        end

        ST_WRITEP: begin
          r_state     <= ST_WENABLEP;
          r_penable   <= 1'b1;
          r_hreadyout <= 1'b1;
        end

        // Pipelined transfer was captured during the stall, so use the delayed copies.
        ST_WENABLEP: begin
          if (!bus.Hwritereg) begin
            r_state     <= ST_READ;
            r_paddr     <= bus.Haddr1;
            r_pwrite    <= 1'b0;
            r_pselx     <= bus.tempselx;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b0;
          end else begin
            r_state     <= bus.valid ? ST_WRITEP : ST_WRITE;
            r_paddr     <= bus.Haddr2;
            r_pwdata    <= bus.Hwdata1;
            r_pwrite    <= 1'b1;
            r_pselx     <= bus.tempselx;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_pselx     <= '0;
          r_penable   <= 1'b0;
          r_hreadyout <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Pselx     = r_pselx;
  assign bus.Penable   = r_penable;
  assign bus.Pwrite    = r_pwrite;
  assign bus.Paddr     = r_paddr;
  assign bus.Pwdata    = r_pwdata;
  assign bus.Hreadyout = r_hreadyout;

  // APB protocol invariants
  a_enable_after_setup: assert property (@(posedge Hclk) disable iff (Hresetin)
    r_penable |-> $past((|r_pselx) && !r_penable));

  a_stable_in_enable: assert property (@(posedge Hclk) disable iff (Hresetin)
    r_penable |-> ($stable(r_paddr) && $stable(r_pwrite) && $stable(r_pwdata)));

  a_sel_onehot: assert property (@(posedge Hclk) disable iff (Hresetin)
    $onehot0(r_pselx));

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller: emulates the upstream delay registers and checks APB outputs per edge.
module tb_apb_fsm_controller;

  logic Hclk;
  logic Hresetin;
  int   n_checks;
  int   n_errors;

  apb_fsm_controller_if #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) bus ();

  apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) dut (
    .Hclk     (Hclk),
    .Hresetin (Hresetin),
    .bus      (bus)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Current-cycle inputs from the AHB side.
  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] s);
    bus.valid    = v;
    bus.Hwrite   = w;
    bus.Haddr    = a;
    bus.Hwdata   = d;
    bus.tempselx = s;
  endtask

  // Advance one edge, then shift the upstream delay registers as the slave interface would.
  task automatic tick();
    @(posedge Hclk);
    #1;
    bus.Haddr2    = bus.Haddr1;
    bus.Haddr1    = bus.Haddr;
    bus.Hwdata1   = bus.Hwdata;
    bus.Hwritereg = bus.Hwrite;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_psel"}, {29'd0, bus.Pselx}, 32'd0);
    chk({tag, "_pen"},  {31'd0, bus.Penable}, 32'd0);
    chk({tag, "_hrdy"}, {31'd0, bus.Hreadyout}, 32'd1);
  endtask

  task automatic chk_setup(input string tag, input logic [31:0] a, input logic w, input logic [2:0] s);
    chk({tag, "_paddr"}, bus.Paddr, a);
    chk({tag, "_pwr"},   {31'd0, bus.Pwrite}, {31'd0, w});
    chk({tag, "_psel"},  {29'd0, bus.Pselx}, {29'd0, s});
    chk({tag, "_pen"},   {31'd0, bus.Penable}, 32'd0);
    chk({tag, "_hrdy"},  {31'd0, bus.Hreadyout}, 32'd0);
  endtask

  task automatic chk_enable(input string tag, input logic [31:0] a, input logic [2:0] s);
    chk({tag, "_paddr"}, bus.Paddr, a);
    chk({tag, "_psel"},  {29'd0, bus.Pselx}, {29'd0, s});
    chk({tag, "_pen"},   {31'd0, bus.Penable}, 32'd1);
    chk({tag, "_hrdy"},  {31'd0, bus.Hreadyout}, 32'd1);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    Hresetin      = 1'b1;
    bus.Haddr1    = '0;
    bus.Haddr2    = '0;
    bus.Hwdata1   = '0;
    bus.Hwritereg = 1'b0;

    // Reset with stimulus active
    drive(1'b1, 1'b0, 32'h0000_1234, 32'h0000_FFFF, 3'b001);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle("rst");
      chk("rst_paddr",  bus.Paddr, 32'd0);
      chk("rst_pwdata", bus.Pwdata, 32'd0);
      chk("rst_pwrite", {31'd0, bus.Pwrite}, 32'd0);
    end
    Hresetin = 1'b0;
    drive(1'b0, 1'b0, 32'h0000_1234, 32'h0, 3'b001);
    tick();
    tick();
    chk_idle("idle_hold");

    // Single read
    drive(1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b001);
    tick();
    chk_setup("rd_setup", 32'h8000_0010, 1'b0, 3'b001);
    drive(1'b0, 1'b0, 32'h8000_0010, 32'h0, 3'b001);
    tick();
    chk_enable("rd_enable", 32'h8000_0010, 3'b001);
    tick();
    chk_idle("rd_done");

    // Single write
    drive(1'b1, 1'b1, 32'h8400_1010, 32'h0, 3'b010);
    tick();
    chk_idle("wr_wwait");
    drive(1'b0, 1'b1, 32'h8400_1010, 32'h0000_0ABD, 3'b010);
    tick();
    chk_setup("wr_setup", 32'h8400_1010, 1'b1, 3'b010);
    chk("wr_setup_pwdata", bus.Pwdata, 32'h0000_0ABD);
    tick();
    chk_enable("wr_enable", 32'h8400_1010, 3'b010);
    chk("wr_enable_pwdata", bus.Pwdata, 32'h0000_0ABD);
    tick();
    chk_idle("wr_done");

    // Back-to-back writes: WWAIT -> WRITEP -> WENABLEP -> WRITE -> WENABLE
    drive(1'b1, 1'b1, 32'h8000_1010, 32'h0, 3'b001);
    tick();
    chk_idle("b2b_wwait");
    drive(1'b1, 1'b1, 32'h8800_1010, 32'h0000_0536, 3'b001);
    tick();
    chk_setup("b2b_setup1", 32'h8000_1010, 1'b1, 3'b001);
    chk("b2b_setup1_pwdata", bus.Pwdata, 32'h0000_0536);
    drive(1'b0, 1'b1, 32'h8800_1010, 32'h0000_0123, 3'b001);
    tick();
    chk_enable("b2b_enable1", 32'h8000_1010, 3'b001);
    chk("b2b_enable1_pwdata", bus.Pwdata, 32'h0000_0536);
    tick();
    chk_setup("b2b_setup2", 32'h8800_1010, 1'b1, 3'b001);
    chk("b2b_setup2_pwdata", bus.Pwdata, 32'h0000_0123);
    drive(1'b0, 1'b1, 32'h8800_1010, 32'h0, 3'b001);
    tick();
    chk_enable("b2b_enable2", 32'h8800_1010, 3'b001);
    chk("b2b_enable2_pwdata", bus.Pwdata, 32'h0000_0123);
    tick();
    chk_idle("b2b_done");

    // Write immediately followed by read: WENABLEP -> READ
    drive(1'b1, 1'b1, 32'h8000_2020, 32'h0, 3'b100);
    tick();
    chk_idle("wr_rd_wwait");
    drive(1'b1, 1'b0, 32'h8C00_1010, 32'h0000_05A5, 3'b100);
    tick();
    chk_setup("wr_rd_wsetup", 32'h8000_2020, 1'b1, 3'b100);
    chk("wr_rd_wsetup_pwdata", bus.Pwdata, 32'h0000_05A5);
    drive(1'b0, 1'b0, 32'h8C00_1010, 32'h0000_05A5, 3'b100);
    tick();
    chk_enable("wr_rd_wenable", 32'h8000_2020, 3'b100);
    drive(1'b0, 1'b0, 32'h8C00_1010, 32'h0, 3'b100);
    tick();
    chk_setup("wr_rd_rsetup", 32'h8C00_1010, 1'b0, 3'b100);
    tick();
    chk_enable("wr_rd_renable", 32'h8C00_1010, 3'b100);
    tick();
    chk_idle("wr_rd_done");

    // Reset during WENABLEP, then a normal read
    drive(1'b1, 1'b1, 32'h8000_1010, 32'h0, 3'b001);
    tick();
    drive(1'b1, 1'b1, 32'h8800_1010, 32'h0000_0536, 3'b001);
    tick();
    drive(1'b0, 1'b1, 32'h8800_1010, 32'h0000_0123, 3'b001);
    tick();
    chk_enable("mid_wenablep", 32'h8000_1010, 3'b001);
    Hresetin = 1'b1;
    tick();
    chk_idle("mid_rst");
    chk("mid_rst_paddr", bus.Paddr, 32'd0);
    Hresetin = 1'b0;
    drive(1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b010);
    tick();
    chk_setup("post_rst_setup", 32'h8000_0010, 1'b0, 3'b010);
    drive(1'b0, 1'b0, 32'h8000_0010, 32'h0, 3'b010);
    tick();
    chk_enable("post_rst_enable", 32'h8000_0010, 3'b010);
    tick();
    chk_idle("post_rst_done");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_fsm_controller.md
Name: apb_fsm_controller

Overview:
- Downstream stage of the AHB slave interface in the AHB-to-APB bridge.
- Consumes the slave interface's outputs: `valid`, the pipelined address/data registers, `Hwritereg` and the decoded `tempselx`.
- Drives the APB master signals (`Pselx`, `Penable`, `Pwrite`, `Paddr`, `Pwdata`) through an 8-state FSM.
- Returns `Hreadyout` to the AHB side so that write pipelining and APB two-phase transfers stall the AHB master correctly. APB slaves are zero-wait-state, so there is no `Pready`.

Parameters:
- ADDR_W, 32, width of `Haddr`/`Paddr`.
- DATA_W, 32, width of `Hwdata`/`Pwdata`.
- NSEL, 3, number of APB slave selects.

Ports:
- Hclk  in  1  system clock; all logic on the rising edge.
- Hresetin  in  1  synchronous, active-high reset.
- valid  in  1  current AHB transfer is valid and addressed to the bridge.
- Hwrite  in  1  direction of the current AHB address phase (1 = write).
- Hwritereg  in  1  `Hwrite` delayed one cycle.
- Haddr  in  ADDR_W  current AHB address.
- Haddr1  in  ADDR_W  `Haddr` delayed 1 cycle.
- Haddr2  in  ADDR_W  `Haddr` delayed 2 cycles.
- Hwdata  in  DATA_W  current AHB write data.
- Hwdata1  in  DATA_W  `Hwdata` delayed 1 cycle.
- tempselx  in  NSEL  one-hot slave decode from the slave interface.
- Pselx  out  NSEL  APB slave select.
- Penable  out  1  APB enable phase.
- Pwrite  out  1  APB direction.
- Paddr  out  ADDR_W  APB address.
- Pwdata  out  DATA_W  APB write data.
- Hreadyout  out  1  AHB ready; 0 stalls the master.

Behaviour:
- Reset: synchronous. While `Hresetin`=1 at a clock edge: state=ST_IDLE, `Pselx`=0, `Penable`=0, `Pwrite`=0, `Paddr`=0, `Pwdata`=0, `Hreadyout`=1.
  - Reset overrides any transfer in progress.
  - Mid-transfer reset drops `Pselx`/`Penable` on the same edge; no completion is generated.
- Registers: all outputs are registered. On each edge, the outputs are loaded according to the transition taken (current state + inputs). Outputs not listed for a transition hold their value.
- States: ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP.
- Transitions:
  - IDLE: `valid`&~`Hwrite` -> READ; `valid`&`Hwrite` -> WWAIT; else IDLE.
  - WWAIT: ~`valid` -> WRITE; `valid` -> WRITEP.
  - READ -> RENABLE (unconditional).
  - WRITE: ~`valid` -> WENABLE; `valid` -> WENABLEP.
  - WRITEP -> WENABLEP (unconditional).
  - RENABLE, WENABLE: same decisions as IDLE.
  - WENABLEP: ~`Hwritereg` -> READ; `Hwritereg`&~`valid` -> WRITE; `Hwritereg`&`valid` -> WRITEP.
- Output actions:
  - Read setup (entering READ from IDLE/RENABLE/WENABLE): `Paddr`=`Haddr`, `Pwrite`=0, `Pselx`=`tempselx`, `Penable`=0, `Hreadyout`=0.
  - Read setup from WENABLEP: same as above, except `Paddr`=`Haddr1`.
  - Enter WWAIT: `Pselx`=0, `Penable`=0, `Hreadyout`=1.
  - Write setup from WWAIT (into WRITE or WRITEP): `Paddr`=`Haddr1`, `Pwdata`=`Hwdata`, `Pwrite`=1, `Pselx`=`tempselx`, `Penable`=0, `Hreadyout`=0.
  - Write setup from WENABLEP (into WRITE or WRITEP): `Paddr`=`Haddr2`, `Pwdata`=`Hwdata1`, `Pwrite`=1, `Pselx`=`tempselx`, `Penable`=0, `Hreadyout`=0.
  - Enter RENABLE/WENABLE/WENABLEP: `Penable`=1, `Hreadyout`=1; `Paddr`, `Pwdata`, `Pselx` held.
  - WRITEP -> WENABLEP: same as entering an enable state.
  - Enter IDLE from an enable state: `Pselx`=0, `Penable`=0, `Hreadyout`=1.
- Latency:
  - Single read: setup phase the cycle after `valid`, enable phase the next cycle. Two APB cycles, with `Hreadyout` low for one.
  - Single write: one WWAIT cycle for data, then setup, then enable.
- APB protocol invariants (assertable):
  - `Penable`=1 only in the cycle after a cycle with `Pselx`!=0 and `Penable`=0.
  - `Paddr`, `Pwrite`, `Pwdata` are stable from setup through enable.
  - `Pselx` is one-hot or zero.
- Back-to-back: a new `valid` during an enable phase starts the next setup with no idle cycle in between.

Test Plan:
- Reset held 2 cycles with stimulus active -> all outputs 0, `Hreadyout`=1; released, stays IDLE while `valid`=0.
- Single read: `Haddr`=0x8000_0010, `tempselx`=001, `valid`=1, `Hwrite`=0 for 1 cycle.
  - Required: `Paddr`=0x8000_0010, `Pselx`=001, `Penable`=0, `Hreadyout`=0 for one cycle.
  - Then `Penable`=1, `Hreadyout`=1.
  - Then `Pselx`=0.
- Single write: `Haddr`=0x8400_1010, `tempselx`=010, then `Hwdata`=0xABD with `valid`=0.
  - Required: WWAIT, then `Paddr`=0x8400_1010, `Pwdata`=0xABD, `Pwrite`=1, `Pselx`=010.
  - Then `Penable`=1, then IDLE.
- Back-to-back writes to 0x8000_1010/0x536 and 0x8800_1010/0x123 (`valid` held).
  - Required path: WWAIT->WRITEP->WENABLEP->WRITE->WENABLE.
  - Second setup: `Paddr`=0x8800_1010, `Pwdata`=0x123.
  - `Hreadyout` low during each setup.
- Write followed immediately by read of 0x8C00_1010 -> WENABLEP->READ, `Paddr`=0x8C00_1010, `Pwrite`=0, then RENABLE.
- Reset asserted during WENABLEP -> next edge: `Pselx`=0, `Penable`=0, `Hreadyout`=1, state IDLE; the following read completes normally.
